data_memory_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory interface.
- Owns a 2^ADDR_WIDTH x DATA_WIDTH word store and services single-word read/write requests from the CPU through a req/ack handshake with a programmable number of wait states.
- After reset it optionally sweeps the store to zero, so programs start from a known memory image.
- Sits between the CPU load/store path and the top level; it is the only owner of data memory.

---
 rtl/data_memory_responder.sv | 105 ++++++++++
 tb/tb_data_memory_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Data-memory responder: word store with req/ack handshake, programmable wait states
// and an optional zero-fill sweep after reset.
//
// state  | meaning
// CLEAR  | zero-fill sweep, one word per cycle
// IDLE   | ready, captures a request
// WAIT   | counting wait states down to the access
// ACCESS | single-cycle read or write of the captured address
// RESP   | one-cycle ack pulse
module data_memory_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int WAIT_STATES    = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  read_write_memory,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_out_memory,
  output logic [DATA_WIDTH-1:0] data_in_memory,
  output logic                  ack,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam logic [3:0]            WAIT_LOAD   = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                state, state_next;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] clr_ptr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_rw;
  logic                  accept;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_CLEAR:  if (clr_ptr == LAST_ADDR) state_next = S_IDLE;
      S_IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      // <=1 rather than ==1 so a corrupted counter cannot stall the FSM
      S_WAIT:   if (wait_cnt <= 4'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign ack  = (state == S_RESP);
  assign busy = !rst_n || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RESET_STATE;
      wait_cnt       <= '0;
      clr_ptr        <= '0;
      cap_addr       <= '0;
      cap_data       <= '0;
      cap_rw         <= 1'b0;
      data_in_memory <= '0;
      overrun        <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        cap_rw   <= read_write_memory;
        cap_addr <= addr;
        cap_data <= data_out_memory;
        wait_cnt <= WAIT_LOAD;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state == S_ACCESS && !cap_rw) data_in_memory <= mem[cap_addr];
      if (req && state != S_IDLE) overrun <= 1'b1;
    end
  end

  // Store has no reset; gating on rst_n means a reset edge never commits a write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR) mem[clr_ptr] <= '0;
      else if (state == S_ACCESS && cap_rw) mem[cap_addr] <= cap_data;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (W=2 clear, W=0 no-clear, W=3 no-clear)
// driven by directed steps with a read-data scoreboard.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n_v [3];
  logic        req_v   [3];
  logic        rw;
  logic [7:0]  a;
  logic [15:0] d;
  logic [15:0] dout    [3];
  logic        ack_v   [3];
  logic        busy_v  [3];
  logic        ovr_v   [3];

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  logic [15:0] model_mem [3][256];
  logic [15:0] last_rd   [3];
  int          wl        [3] = '{2, 0, 3};

  always #5 clk = ~clk;

  data_memory_responder #(.WAIT_STATES(2), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_v[0]), .read_write_memory(rw), .addr(a),
    .data_out_memory(d), .data_in_memory(dout[0]), .ack(ack_v[0]), .busy(busy_v[0]),
    .overrun(ovr_v[0]));

  data_memory_responder #(.WAIT_STATES(0), .CLEAR_ON_RESET(0)) u_b (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_v[1]), .read_write_memory(rw), .addr(a),
    .data_out_memory(d), .data_in_memory(dout[1]), .ack(ack_v[1]), .busy(busy_v[1]),
    .overrun(ovr_v[1]));

  data_memory_responder #(.WAIT_STATES(3), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .rst_n(rst_n_v[2]), .req(req_v[2]), .read_write_memory(rw), .addr(a),
    .data_out_memory(d), .data_in_memory(dout[2]), .ack(ack_v[2]), .busy(busy_v[2]),
    .overrun(ovr_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the instance idle; returns at the negedge after the ack cycle.
  task automatic do_access(input int s, input bit wr, input logic [7:0] ad,
                           input logic [15:0] dd, input string tag, input bit extra);
    int   n;
    exp_t e;
    if (wr) begin
      model_mem[s][ad] = dd;
      e.data = last_rd[s];
    end else begin
      e.data = model_mem[s][ad];
      last_rd[s] = e.data;
    end
    e.tag = tag;
    sb.push_back(e);
    rw = wr; a = ad; d = dd; req_v[s] = 1'b1;
    @(negedge clk);
    n = 0;
    if (extra) begin
      rw = ~wr; a = ~ad; d = ~dd;
      @(negedge clk);
      n = 1;
    end
    req_v[s] = 1'b0;
    while (!ack_v[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, wl[s] + 1);
    if (ack_v[s]) begin
      e = sb.pop_front();
      chk(e.tag, dout[s], e.data);
      chk({tag, "_busy_in_ack"}, busy_v[s], 1'b1);
    end
    @(negedge clk);
    chk({tag, "_ack_one_cycle"}, ack_v[s], 1'b0);
    chk({tag, "_idle_after"}, busy_v[s], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int s = 0; s < 3; s++) begin
      rst_n_v[s] = 1'b0;
      req_v[s]   = 1'b0;
      last_rd[s] = 16'h0000;
      for (int i = 0; i < 256; i++) model_mem[s][i] = 16'h0000;
    end
    rw = 1'b0; a = '0; d = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_busy_%0d", s), busy_v[s], 1'b1);
      chk($sformatf("rst_ack_%0d", s), ack_v[s], 1'b0);
      chk($sformatf("rst_overrun_%0d", s), ovr_v[s], 1'b0);
      chk($sformatf("rst_dout_%0d", s), dout[s], 16'h0000);
    end

    for (int s = 0; s < 3; s++) rst_n_v[s] = 1'b1;
    #1;
    chk("noclear_idle_b", busy_v[1], 1'b0);
    chk("noclear_idle_c", busy_v[2], 1'b0);
    n = 0;
    while (busy_v[0] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("clear_busy_cycles", n, 256);

    do_access(0, 1'b0, 8'hFF, 16'h0000, "clear_read_ff", 1'b0);
    do_access(0, 1'b1, 8'h12, 16'hBEEF, "wr_beef", 1'b0);
    do_access(0, 1'b0, 8'h12, 16'h0000, "rd_beef", 1'b0);

    chk("overrun_before", ovr_v[0], 1'b0);
    do_access(0, 1'b1, 8'h30, 16'h5A5A, "wr_with_overrun", 1'b1);
    chk("overrun_set", ovr_v[0], 1'b1);
    do_access(0, 1'b0, 8'h30, 16'h0000, "rd_after_overrun", 1'b0);
    do_access(0, 1'b0, 8'hCF, 16'h0000, "ignored_req_no_write", 1'b0);
    chk("overrun_sticky", ovr_v[0], 1'b1);

    do_access(0, 1'b1, 8'h00, 16'hFFFF, "wr_addr_00", 1'b0);
    do_access(0, 1'b1, 8'hFF, 16'h8001, "wr_addr_ff", 1'b0);
    do_access(0, 1'b0, 8'h00, 16'h0000, "rd_addr_00", 1'b0);
    do_access(0, 1'b0, 8'hFF, 16'h0000, "rd_addr_ff", 1'b0);

    do_access(1, 1'b1, 8'h00, 16'h1111, "w0_prefill", 1'b0);
    do_access(1, 1'b0, 8'h00, 16'h0000, "w0_rd_00", 1'b0);
    do_access(1, 1'b1, 8'h01, 16'hA5A5, "w0_wr_01_hold", 1'b0);
    do_access(1, 1'b0, 8'h01, 16'h0000, "w0_rd_01", 1'b0);
    chk("w0_no_overrun", ovr_v[1], 1'b0);

    do_access(2, 1'b1, 8'h40, 16'h0000, "abort_prefill", 1'b0);
    rw = 1'b1; a = 8'h40; d = 16'h1234; req_v[2] = 1'b1;
    @(negedge clk);
    req_v[2] = 1'b0;
    @(negedge clk);
    chk("abort_in_wait_busy", busy_v[2], 1'b1);
    rst_n_v[2] = 1'b0;
    req_v[2]   = 1'b1;
    @(negedge clk);
    chk("abort_no_ack_1", ack_v[2], 1'b0);
    @(negedge clk);
    chk("abort_no_ack_2", ack_v[2], 1'b0);
    req_v[2] = 1'b0;
    rst_n_v[2] = 1'b1;
    last_rd[2] = 16'h0000;
    #1;
    chk("abort_idle_after_reset", busy_v[2], 1'b0);
    chk("abort_req_in_reset_no_overrun", ovr_v[2], 1'b0);
    chk("abort_dout_cleared", dout[2], 16'h0000);
    @(negedge clk);
    do_access(2, 1'b0, 8'h40, 16'h0000, "abort_rd_40", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
